// File: rtl/msb_pkg.sv
// Shared widths and mode encoding for the first-one detector.
// Combinational helpers only; no state.
// No handshake; consumed at elaboration time.
package msb_pkg;

    localparam logic MODE_MSB = 1'b0;
    localparam logic MODE_LSB = 1'b1;

    // Width needed to hold a 1-based bit position 0..dw inclusive.
    function automatic int pos_w(input int dw);
        return $clog2(dw) + 1;
    endfunction

    // Local bit index inside one segment; never narrower than one bit.
    function automatic int seg_idx_w(input int seg_w);
        return (seg_w > 1) ? $clog2(seg_w) : 1;
    endfunction

endpackage

// File: rtl/seg_prio_enc.sv
// Priority encoder for one segment: highest or lowest set bit plus a non-zero flag.
// Latency: purely combinational.
// Backpressure: none; the enclosing pipeline registers its outputs.
module seg_prio_enc
    import msb_pkg::*;
#(
    parameter  int SEG_W = 8,
    localparam int IDX_W = seg_idx_w(SEG_W)
) (
    input  logic [SEG_W-1:0] seg,
    input  logic             lsb_mode,
    output logic             nz,
    output logic [IDX_W-1:0] idx
);

    // The last match of the scan wins, so the scan direction picks the end.
    always_comb begin
        nz  = |seg;
        idx = '0;
        if (lsb_mode == MODE_LSB) begin
            for (int i = SEG_W - 1; i >= 0; i--) begin
                if (seg[i]) begin
                    idx = IDX_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < SEG_W; i++) begin
                if (seg[i]) begin
                    idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/msb_detector_pipe.sv
// Two-stage first-one detector: per-segment encoders, then segment select and position add.
// Latency: word accepted at edge N is transferred downstream at edge N+2.
// Backpressure: two-entry pipeline; in_ready follows out_ready combinationally once both stages are full.
module msb_detector_pipe
    import msb_pkg::*;
#(
    parameter  int DW_IN = 512,
    parameter  int SEG_W = 8,
    localparam int POS_W = pos_w(DW_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW_IN-1:0] in_data,
    input  logic             in_lsb_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [POS_W-1:0] out_pos,
    output logic             out_found
);

    localparam int NSEG   = DW_IN / SEG_W;
    localparam int IDX_W  = seg_idx_w(SEG_W);
    localparam int SEGK_W = (NSEG > 1) ? $clog2(NSEG) : 1;

    logic [NSEG-1:0]            seg_nz;
    logic [NSEG-1:0][IDX_W-1:0] seg_idx;

    logic [NSEG-1:0]            s1_nz;
    logic [NSEG-1:0][IDX_W-1:0] s1_idx;
    logic                       s1_mode;
    logic                       s1_valid;

    logic                       ready_en;
    logic                       s2_load;
    logic                       s1_load;
    logic                       in_fire;

    logic [SEGK_W-1:0]          sel_seg;
    logic [IDX_W-1:0]           sel_idx;
    logic                       sel_found;
    logic [POS_W-1:0]           sel_pos;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        seg_prio_enc #(
            .SEG_W    (SEG_W)
        ) u_enc (
            .seg      (in_data[k*SEG_W +: SEG_W]),
            .lsb_mode (in_lsb_mode),
            .nz       (seg_nz[k]),
            .idx      (seg_idx[k])
        );
    end

    // S2 drains and S1 refills on the same edge, so a flowing pipe never bubbles.
    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load && ready_en;
    assign in_fire  = in_valid && in_ready;

    // Holds in_ready low through reset and for the edge that releases it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_MSB;
            s1_nz    <= '0;
            s1_idx   <= '0;
        end else if (s1_load) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_mode <= in_lsb_mode;
                s1_nz   <= seg_nz;
                s1_idx  <= seg_idx;
            end
        end
    end

    always_comb begin
        sel_seg   = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        if (s1_mode == MODE_LSB) begin
            for (int k = NSEG - 1; k >= 0; k--) begin
                if (s1_nz[k]) begin
                    sel_seg   = SEGK_W'(k);
                    sel_idx   = s1_idx[k];
                    sel_found = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < NSEG; k++) begin
                if (s1_nz[k]) begin
                    sel_seg   = SEGK_W'(k);
                    sel_idx   = s1_idx[k];
                    sel_found = 1'b1;
                end
            end
        end
    end

    // SEG_W is a power of two, so k*SEG_W is a shift; the result tops out at DW_IN.
    always_comb begin
        sel_pos = '0;
        if (sel_found) begin
            sel_pos = (POS_W'(sel_seg) << IDX_W) + POS_W'(sel_idx) + POS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pos   <= '0;
            out_found <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_pos   <= sel_pos;
                out_found <= sel_found;
            end
        end
    end

endmodule

// File: tb/tb_msb_detector_pipe.sv
// Bench for msb_detector_pipe: table of single words, back-to-back stream, stalls and mid-stream reset.
module tb_msb_detector_pipe;

    localparam int DW = 512;
    localparam int PW = 10;
    localparam int NV = 10;

    typedef struct {
        logic [DW-1:0] data;
        logic          mode;
        logic [PW-1:0] pos;
        logic          found;
    } vec_t;

    typedef struct {
        logic [PW-1:0] pos;
        logic          found;
        int            acc_cyc;
    } sb_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_lsb_mode;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_pos;
    logic          out_found;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   n_out    = 0;
    bit   chk_lat  = 1'b1;
    bit   stall_prev = 1'b0;
    logic [PW-1:0] stall_pos;
    logic          stall_found;
    sb_t  sb[$];
    vec_t vecs[NV];

    msb_detector_pipe #(
        .DW_IN       (DW),
        .SEG_W       (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_lsb_mode (in_lsb_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pos     (out_pos),
        .out_found   (out_found)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [DW-1:0] onebit(input int b);
        logic [DW-1:0] v;
        v    = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    // Plain bit-by-bit scan over the whole word.
    function automatic logic [PW-1:0] ref_pos(input logic [DW-1:0] d, input logic lsb);
        logic [PW-1:0] p;
        p = '0;
        for (int b = 0; b < DW; b++) begin
            if (d[b] && (!lsb || p == '0)) p = PW'(b + 1);
        end
        return p;
    endfunction

    function automatic vec_t mk(input logic [DW-1:0] d, input logic m, input int p, input logic f);
        vec_t v;
        v.data  = d;
        v.mode  = m;
        v.pos   = PW'(p);
        v.found = f;
        return v;
    endfunction

    function automatic logic [DW-1:0] rand_word(input int i);
        logic [DW-1:0] d;
        for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom();
        if (i % 3 == 0) d = onebit($urandom_range(0, DW - 1));
        if (i % 7 == 4) d = '0;
        return d;
    endfunction

    // One clock: drive after the edge, then sample everything at the falling edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic m, input logic ordy,
                        input logic [PW-1:0] ep, input logic ef, output logic acc);
        sb_t e;
        @(posedge clk);
        #2;
        in_valid    = v;
        in_data     = d;
        in_lsb_mode = m;
        out_ready   = ordy;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got pos=%0d with no word outstanding (cycle %0d)", out_pos, cyc);
            end else begin
                e = sb.pop_front();
                check("out_pos", out_pos, e.pos);
                check("out_found", out_found, e.found);
                if (chk_lat) check("latency", cyc + 1 - e.acc_cyc, 2);
            end
        end
        if (out_valid && !out_ready) begin
            if (stall_prev) begin
                check("stall_pos_stable", out_pos, stall_pos);
                check("stall_found_stable", out_found, stall_found);
            end
            stall_prev  = 1'b1;
            stall_pos   = out_pos;
            stall_found = out_found;
        end else begin
            stall_prev = 1'b0;
        end
        if (acc) begin
            e.pos     = ep;
            e.found   = ef;
            e.acc_cyc = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic m, input logic [PW-1:0] ep,
                        input logic ef, input logic ordy);
        logic acc;
        int   n;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            step(1'b1, d, m, ordy, ep, ef, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stayed %0d for %0d cycles, expected 1", in_ready, n);
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1, '0, 1'b0, acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            idle(1);
            n++;
        end
        check("drain_outstanding", sb.size(), 0);
    endtask

    initial begin
        logic          acc;
        logic          last;
        logic [DW-1:0] wd[20];
        logic          wm[20];
        logic [DW-1:0] d;
        logic          m;
        int            idx, na, nb, n0, miss;

        vecs[0] = mk(onebit(511), 1'b0, 512, 1'b1);
        vecs[1] = mk(onebit(300), 1'b0, 301, 1'b1);
        vecs[2] = mk(onebit(0),   1'b0, 1,   1'b1);
        vecs[3] = mk('0,          1'b0, 0,   1'b0);
        vecs[4] = mk('1,          1'b0, 512, 1'b1);
        vecs[5] = mk('1,          1'b1, 1,   1'b1);
        vecs[6] = mk(onebit(5) | onebit(200), 1'b1, 6,   1'b1);
        vecs[7] = mk(onebit(5) | onebit(200), 1'b0, 201, 1'b1);
        vecs[8] = mk(onebit(7) | onebit(8),   1'b1, 8,   1'b1);
        vecs[9] = mk(onebit(7) | onebit(8),   1'b0, 9,   1'b1);

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_lsb_mode = 1'b0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_pos", out_pos, 0);
        check("reset_out_found", out_found, 0);
        check("reset_in_ready", in_ready, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(1);
        check("in_ready_after_release", in_ready, 1);
        check("idle_out_valid", out_valid, 0);

        for (int i = 0; i < NV; i++) begin
            send(vecs[i].data, vecs[i].mode, vecs[i].pos, vecs[i].found, 1'b1);
            idle(3);
        end
        drain();

        // Back-to-back stream with the sink always ready.
        n0   = n_out;
        miss = 0;
        for (int i = 0; i < 20; i++) begin
            d = rand_word(i);
            m = 1'($urandom_range(0, 1));
            step(1'b1, d, m, 1'b1, ref_pos(d, m), ref_pos(d, m) != '0, acc);
            if (!acc) miss++;
        end
        drain();
        check("stream_in_ready_drops", miss, 0);
        check("stream_result_count", n_out - n0, 20);

        // Stalled stream: one stall from empty, one with both stages full.
        for (int i = 0; i < 20; i++) begin
            wd[i] = rand_word(i + 1);
            wm[i] = 1'($urandom_range(0, 1));
        end
        chk_lat = 1'b0;
        n0  = n_out;
        idx = 0;
        for (int c = 0; c < 40 && idx < 10; c++) begin
            step(1'b1, wd[idx], wm[idx], 1'b1, ref_pos(wd[idx], wm[idx]), ref_pos(wd[idx], wm[idx]) != '0, acc);
            if (acc) idx++;
        end
        idle(3);
        na   = 0;
        last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, wd[idx], wm[idx], 1'b0, ref_pos(wd[idx], wm[idx]), ref_pos(wd[idx], wm[idx]) != '0, acc);
            if (acc) begin
                idx++;
                na++;
            end
            last = acc;
        end
        check("stall_empty_accepts", na, 2);
        check("stall_empty_in_ready_3rd", last, 0);
        for (int c = 0; c < 40 && idx < 16; c++) begin
            step(1'b1, wd[idx], wm[idx], 1'b1, ref_pos(wd[idx], wm[idx]), ref_pos(wd[idx], wm[idx]) != '0, acc);
            if (acc) idx++;
        end
        nb = 0;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, wd[idx], wm[idx], 1'b0, ref_pos(wd[idx], wm[idx]), ref_pos(wd[idx], wm[idx]) != '0, acc);
            if (acc) begin
                idx++;
                nb++;
            end
        end
        check("stall_full_accepts", nb, 0);
        for (int c = 0; c < 40 && idx < 20; c++) begin
            step(1'b1, wd[idx], wm[idx], 1'b1, ref_pos(wd[idx], wm[idx]), ref_pos(wd[idx], wm[idx]) != '0, acc);
            if (acc) idx++;
        end
        drain();
        check("stall_result_count", n_out - n0, 20);
        chk_lat = 1'b1;

        // Fill both stages, then reset in the middle of the stall.
        send(onebit(10), 1'b0, 11, 1'b1, 1'b0);
        send(onebit(20), 1'b1, 21, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_out_pos", out_pos, 0);
        check("midreset_out_found", out_found, 0);
        check("midreset_in_ready", in_ready, 0);
        sb.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        n0 = n_out;
        send(onebit(63), 1'b0, 64, 1'b1, 1'b1);
        idle(4);
        check("post_reset_result_count", n_out - n0, 1);
        check("post_reset_outstanding", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
